// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: symbol width, K28.5 comma patterns, receive FSM
// state encoding and a small saturating-counter helper.
// All symbol vectors are [0:SYM_W-1], so index 0 is the first bit on the wire.
package serdes_pkg;

   localparam int SYM_W = 10;

   // K28.5 with running disparity negative / positive, abcdeifghj order
   localparam logic [0:SYM_W-1] K28_5_RDN = 10'b0011111010;
   localparam logic [0:SYM_W-1] K28_5_RDP = 10'b1100000101;

   // Receive alignment FSM encoding
   localparam logic [1:0] ST_HUNT  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_SYNC  = 2'd2;

   // 4-bit increment that sticks at 15
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma finder: compares a full symbol window against both
// disparities of the comma character.
module comma_detect
   import serdes_pkg::*;
#(
   parameter int               WIDTH   = SYM_W,
   parameter logic [0:WIDTH-1] COMMA_P = K28_5_RDN,
   parameter logic [0:WIDTH-1] COMMA_N = K28_5_RDP
) (
   input  logic [0:WIDTH-1] win_i,
   output logic             is_comma_o
);

   assign is_comma_o = (win_i == COMMA_P) | (win_i == COMMA_N);

endmodule

// File: rtl/sipo_comma_align.sv
// Serial-to-parallel receive stage with comma-based word alignment.
// HUNT waits for any comma, CHECK counts boundary-aligned commas until
// LOCK_COUNT is reached, SYNC is the locked state. A comma seen off the
// current boundary moves the boundary (realign) and restarts the count.
module sipo_comma_align
   import serdes_pkg::*;
#(
   parameter int               WIDTH      = SYM_W,
   parameter logic [0:WIDTH-1] COMMA_P    = K28_5_RDN,
   parameter logic [0:WIDTH-1] COMMA_N    = K28_5_RDP,
   parameter int               LOCK_COUNT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   output logic [0:WIDTH-1] parallel_out,
   output logic             data_valid,
   output logic             comma_det,
   output logic             locked,
   output logic             realign
);

   localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);
   localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
   // With a single required comma the first one found already means lock
   localparam logic [1:0] ST_FIRST = (LOCK_COUNT == 1) ? ST_SYNC : ST_CHECK;

   // The oldest history bit drops out of the window on the same edge it
   // would be shifted out, so only bits 1..WIDTH-1 are stored.
   logic [1:WIDTH-1] sr_q;
   logic [0:WIDTH-1] win;
   logic             is_comma;

   logic [1:0]       state_q, state_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [3:0]       comma_cnt_q, comma_cnt_d;
   logic [3:0]       cnt_inc;
   logic [0:WIDTH-1] pout_q, pout_d;
   logic             dv_q, dv_d;
   logic             cd_q, cd_d;
   logic             rl_q, rl_d;
   logic             locked_q;
   logic             at_bnd;

   // Window includes the bit being sampled on this edge
   assign win    = {sr_q, serial_in};
   assign at_bnd = (bit_cnt_q == LAST_BIT);

   comma_detect #(
      .WIDTH   (WIDTH),
      .COMMA_P (COMMA_P),
      .COMMA_N (COMMA_N)
   ) u_comma_detect (
      .win_i      (win),
      .is_comma_o (is_comma)
   );

   // Alignment FSM, bit/comma counters and capture decision
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      comma_cnt_d = comma_cnt_q;
      pout_d      = pout_q;
      dv_d        = 1'b0;
      cd_d        = 1'b0;
      rl_d        = 1'b0;
      cnt_inc     = sat_inc4(comma_cnt_q);
      case (state_q)
         ST_HUNT: begin
            if (is_comma) begin
               pout_d      = win;
               dv_d        = 1'b1;
               cd_d        = 1'b1;
               bit_cnt_d   = 4'd0;
               comma_cnt_d = 4'd1;
               state_d     = ST_FIRST;
            end
         end
         ST_CHECK, ST_SYNC: begin
            if (is_comma && !at_bnd) begin
               // Comma off the expected boundary: adopt the new boundary
               pout_d      = win;
               dv_d        = 1'b1;
               cd_d        = 1'b1;
               rl_d        = 1'b1;
               bit_cnt_d   = 4'd0;
               comma_cnt_d = 4'd1;
               state_d     = ST_FIRST;
            end else if (at_bnd) begin
               pout_d    = win;
               dv_d      = 1'b1;
               bit_cnt_d = 4'd0;
               if (is_comma) begin
                  cd_d        = 1'b1;
                  comma_cnt_d = cnt_inc;
                  if (state_q == ST_CHECK && cnt_inc == LOCK_N)
                     state_d = ST_SYNC;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         default: state_d = ST_HUNT;
      endcase
   end

   // State and output registers; locked follows the next state so it rises
   // together with the valid of the locking comma
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q        <= '0;
         state_q     <= ST_HUNT;
         bit_cnt_q   <= 4'd0;
         comma_cnt_q <= 4'd0;
         pout_q      <= '0;
         dv_q        <= 1'b0;
         cd_q        <= 1'b0;
         rl_q        <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         sr_q        <= win[1:WIDTH-1];
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         pout_q      <= pout_d;
         dv_q        <= dv_d;
         cd_q        <= cd_d;
         rl_q        <= rl_d;
         locked_q    <= (state_d == ST_SYNC);
      end
   end

   assign parallel_out = pout_q;
   assign data_valid   = dv_q;
   assign comma_det    = cd_q;
   assign realign      = rl_q;
   assign locked       = locked_q;

endmodule

// File: tb/tb_sipo_comma_align.sv
// Bench for sipo_comma_align: every expected captured word is queued when its
// bits are driven and checked by a monitor when data_valid fires.
module tb_sipo_comma_align;

   localparam logic [0:9] CP   = 10'b0011111010;
   localparam logic [0:9] CN   = 10'b1100000101;
   localparam logic [0:9] ALT  = 10'b0101010101;
   localparam logic [0:9] D33  = 10'b1100110011;

   typedef struct {
      logic [0:9] word;  // word driven, and the word expected on parallel_out
      logic       cd;
      logic       lk;
      logic       rl;
      int         gap;   // required cycles since previous valid, 0 = unchecked
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       sin_tb;
   logic       use_piso;
   logic       serial_in;
   logic [0:9] parallel_out;
   logic       data_valid, comma_det, locked, realign;

   // Behavioural piso: load a word, then shift it out index 0 first
   logic [0:9] piso_sh = '0;
   logic [0:9] piso_data;
   logic       piso_load;
   logic       piso_ou;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_dv = 0;
   vec_t sbq[$];
   vec_t mon_e;
   vec_t tbl[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (piso_load) piso_sh <= piso_data;
      else           piso_sh <= {piso_sh[1:9], 1'b0};
   end
   assign piso_ou   = piso_sh[0];
   assign serial_in = use_piso ? piso_ou : sin_tb;

   sipo_comma_align dut (
      .clk          (clk),
      .reset        (reset),
      .serial_in    (serial_in),
      .parallel_out (parallel_out),
      .data_valid   (data_valid),
      .comma_det    (comma_det),
      .locked       (locked),
      .realign      (realign)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (realign && !data_valid) chk("realign_without_valid", 1, 0);
      if (data_valid) begin
         if (sbq.size() == 0) begin
            chk("unexpected_valid_word", {22'd0, parallel_out}, 32'hFFFF_FFFF);
         end else begin
            mon_e = sbq.pop_front();
            chk("parallel_out", {22'd0, parallel_out}, {22'd0, mon_e.word});
            chk("comma_det", {31'd0, comma_det}, {31'd0, mon_e.cd});
            chk("locked", {31'd0, locked}, {31'd0, mon_e.lk});
            chk("realign", {31'd0, realign}, {31'd0, mon_e.rl});
            if (mon_e.gap > 0) chk("valid_spacing", cyc - last_dv, mon_e.gap);
         end
         last_dv = cyc;
      end
   end

   task automatic send_bit(input logic b);
      sin_tb = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [0:9] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   task automatic push(input logic [0:9] w, input logic cd, input logic lk,
                       input logic rl, input int gap);
      vec_t v;
      v.word = w; v.cd = cd; v.lk = lk; v.rl = rl; v.gap = gap;
      sbq.push_back(v);
   endtask

   task automatic run_table();
      for (int i = 0; i < tbl.size(); i++) begin
         sbq.push_back(tbl[i]);
         send_word(tbl[i].word);
      end
      tbl.delete();
   endtask

   // Clock until every queued word has appeared, bounded
   task automatic drain();
      int n = 0;
      while (sbq.size() > 0 && n < 30) begin
         send_bit(1'b0);
         n++;
      end
      chk("words_outstanding", sbq.size(), 0);
      sbq.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sin_tb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic piso_send(input logic [0:9] w);
      piso_data = w;
      piso_load = 1'b1;
      @(posedge clk);
      #1;
      piso_load = 1'b0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic add(input logic [0:9] w, input logic cd, input logic lk,
                      input logic rl, input int gap);
      vec_t v;
      v.word = w; v.cd = cd; v.lk = lk; v.rl = rl; v.gap = gap;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; sin_tb = 1'b0; use_piso = 1'b0;
      piso_data = '0; piso_load = 1'b0;

      // Reset held while the line toggles: every output stays zero
      for (int i = 0; i < 4; i++) begin
         sin_tb = i[0];
         @(posedge clk);
         #1;
         chk("rst_parallel_out", {22'd0, parallel_out}, 0);
         chk("rst_data_valid", {31'd0, data_valid}, 0);
         chk("rst_comma_det", {31'd0, comma_det}, 0);
         chk("rst_locked", {31'd0, locked}, 0);
         chk("rst_realign", {31'd0, realign}, 0);
      end
      reset = 1'b0;

      // Hunt: 13 zeros then a comma
      send_zeros(13);
      add(CP, 1, 0, 0, 0);
      run_table();
      // Lock: non-comma then two more aligned commas
      add(ALT, 0, 0, 0, 10);
      add(CP,  1, 0, 0, 10);
      add(CP,  1, 1, 0, 10);
      run_table();

      // Slip: 7 filler bits, so the boundary word ends inside the next comma
      push(10'b0101010110, 0, 1, 0, 10);
      for (int i = 0; i < 7; i++) send_bit(i[0]);
      push(CN, 1, 0, 1, 7);
      send_word(CN);
      add(CP, 1, 0, 0, 10);
      add(CN, 1, 1, 0, 10);
      run_table();
      drain();
      do_reset();

      // Lock, then reset mid-word: locked drops without waiting for a clock
      add(CP, 1, 0, 0, 0);
      add(CP, 1, 0, 0, 10);
      add(CP, 1, 1, 0, 10);
      run_table();
      chk("locked_before_mid_reset", {31'd0, locked}, 1);
      for (int i = 0; i < 5; i++) send_bit(CP[i]);
      reset = 1'b1;
      #1;
      chk("async_reset_locked", {31'd0, locked}, 0);
      chk("async_reset_valid", {31'd0, data_valid}, 0);
      chk("async_reset_word", {22'd0, parallel_out}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      // Remainder of the interrupted word and a data word: HUNT stays silent
      for (int i = 5; i < 10; i++) send_bit(CP[i]);
      send_word(ALT);
      send_zeros(13);
      chk("no_lock_after_reset", {31'd0, locked}, 0);
      add(CP, 1, 0, 0, 0);
      run_table();
      drain();
      do_reset();

      // Mixed disparity commas on the boundary
      add(CP, 1, 0, 0, 0);
      add(CN, 1, 0, 0, 10);
      add(CP, 1, 1, 0, 10);
      add(CN, 1, 1, 0, 10);
      run_table();
      drain();
      do_reset();

      // End to end through the serializer model
      use_piso = 1'b1;
      push(CP,  1, 0, 0, 0);
      push(CP,  1, 0, 0, 10);
      push(CP,  1, 1, 0, 10);
      push(D33, 0, 1, 0, 10);
      piso_send(CP);
      piso_send(CP);
      piso_send(CP);
      piso_send(D33);
      drain();
      chk("e2e_locked", {31'd0, locked}, 1);
      use_piso = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
